// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the execute-stage ALU.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the multiplier runs out of set bits.

`ifndef WORD
`define WORD 64
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'b1111
`endif

module alu_mul_sequencer #(
    parameter int WIDTH = `WORD,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = `ALU_PASS;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                alu_ctrl = `ALU_ADD;
                alu_a    = acc_q;
                alu_b    = mplier_q[0] ? mcand_q : '0;
`ifdef MUL_EARLY_EXIT_EN
                if (mplier_q == '0) begin
                    // Nothing left to add: acc already holds the product.
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else begin
                    acc_d    = alu_result;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    if (count_q == LAST) begin
                        product_d = alu_result;
                        state_d   = S_DONE;
                    end
                end
`else
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // Product latches the final sum as it enters acc.
                if (count_q == LAST) begin
                    product_d = alu_result;
                    state_d   = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
